// File: rtl/pipe_ctrl.sv
// Front-end pipeline control: per-stage stall chaining and
// redirect/flush sequencing for exceptions and branch mispredicts.
module pipe_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_req_if,
    input  logic                  stall_req_id,
    input  logic                  stall_req_rn,
    input  logic                  exc_valid,
    input  logic [ADDR_WIDTH-1:0] exc_pc,
    input  logic                  br_miss_valid,
    input  logic [ADDR_WIDTH-1:0] br_target,
    output logic                  stall_pc,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  stall_rn,
    output logic                  flush_front,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [CNT_WIDTH-1:0]  redirect_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic                  pend_exc_q, pend_exc_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  fire;

    // Next-state, pending-target capture and stall/flush outputs
    always_comb begin
        state_d     = state_q;
        pend_pc_d   = pend_pc_q;
        pend_exc_d  = pend_exc_q;
        fire        = 1'b0;
        flush_front = 1'b0;
        stall_rn    = stall_req_rn;
        stall_id    = stall_req_id | stall_req_rn;
        stall_if    = stall_req_if | stall_req_id | stall_req_rn;
        stall_pc    = stall_req_if | stall_req_id | stall_req_rn;
        unique case (state_q)
            IDLE: begin
                if (exc_valid) begin
                    pend_pc_d  = exc_pc;
                    pend_exc_d = 1'b1;
                    state_d    = FLUSH;
                end else if (br_miss_valid) begin
                    pend_pc_d  = br_target;
                    pend_exc_d = 1'b0;
                    state_d    = FLUSH;
                end
            end
            FLUSH, DRAIN: begin
                flush_front = 1'b1;
                stall_rn    = 1'b0;
                stall_id    = 1'b0;
                stall_if    = stall_req_if;
                stall_pc    = stall_req_if;
                // A newer redirect restarts the flush; a branch
                // never displaces a pending exception.
                if (exc_valid) begin
                    pend_pc_d  = exc_pc;
                    pend_exc_d = 1'b1;
                    state_d    = FLUSH;
                end else if (br_miss_valid && !pend_exc_q) begin
                    pend_pc_d  = br_target;
                    pend_exc_d = 1'b0;
                    state_d    = FLUSH;
                end else if (!stall_req_if) begin
                    fire    = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset aborts an in-flight flush without emitting its redirect
    always_comb begin
        redirect_valid = fire & ~rst;
        redirect_pc    = (state_q == IDLE) ? '0 : pend_pc_q;
        redirect_cnt   = cnt_q;
    end

    // State, pending target and redirect counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_pc_q  <= '0;
            pend_exc_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pend_pc_q  <= pend_pc_d;
            pend_exc_q <= pend_exc_d;
            if (fire) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed table-driven bench for pipe_ctrl (2-bit counter build
// so that counter wrap is reachable in a short run).
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_req_if, stall_req_id, stall_req_rn;
    logic        exc_valid, br_miss_valid;
    logic [31:0] exc_pc, br_target;
    logic        stall_pc, stall_if, stall_id, stall_rn;
    logic        flush_front, redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  redirect_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .ADDR_WIDTH(32),
        .CNT_WIDTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_req_if  (stall_req_if),
        .stall_req_id  (stall_req_id),
        .stall_req_rn  (stall_req_rn),
        .exc_valid     (exc_valid),
        .exc_pc        (exc_pc),
        .br_miss_valid (br_miss_valid),
        .br_target     (br_target),
        .stall_pc      (stall_pc),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .stall_rn      (stall_rn),
        .flush_front   (flush_front),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .redirect_cnt  (redirect_cnt)
    );

    typedef struct {
        logic        r, sif, sid, srn, exc, br;
        logic [31:0] epc, bt;
        logic        e_spc, e_sif, e_sid, e_srn, e_fl, e_rv;
        logic [31:0] e_pc;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic r, input logic sif, input logic sid,
        input logic srn, input logic exc, input logic [31:0] epc,
        input logic br, input logic [31:0] bt,
        input logic e_spc, input logic e_sif, input logic e_sid,
        input logic e_srn, input logic e_fl, input logic e_rv,
        input logic [31:0] e_pc, input logic [1:0] e_cnt);
        vec_t v;
        v.r = r; v.sif = sif; v.sid = sid; v.srn = srn;
        v.exc = exc; v.epc = epc; v.br = br; v.bt = bt;
        v.e_spc = e_spc; v.e_sif = e_sif; v.e_sid = e_sid;
        v.e_srn = e_srn; v.e_fl = e_fl; v.e_rv = e_rv;
        v.e_pc = e_pc; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.r; stall_req_if = v.sif; stall_req_id = v.sid;
        stall_req_rn = v.srn; exc_valid = v.exc; exc_pc = v.epc;
        br_miss_valid = v.br; br_target = v.bt;
    endtask

    task automatic idle_in();
        rst = 1'b0; stall_req_if = 1'b0; stall_req_id = 1'b0;
        stall_req_rn = 1'b0; exc_valid = 1'b0; br_miss_valid = 1'b0;
        exc_pc = '0; br_target = '0;
    endtask

    int          pulses;
    logic [31:0] seen_pc;

    initial begin
        // r sif sid srn exc epc br bt | spc sif sid srn fl rv pc cnt
        tbl.push_back(mk(1,0,1,0, 0,0, 0,0, 1,1,1,0,0,0,32'h0,0));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0,0,0,0,32'h0,0));
        tbl.push_back(mk(0,0,1,0, 0,0, 0,0, 1,1,1,0,0,0,32'h0,0));
        tbl.push_back(mk(0,0,0,1, 0,0, 0,0, 1,1,1,1,0,0,32'h0,0));
        tbl.push_back(mk(0,1,0,0, 0,0, 0,0, 1,1,0,0,0,0,32'h0,0));
        tbl.push_back(mk(0,0,0,0, 0,0, 1,32'h8000_0100,
                         0,0,0,0,0,0,32'h0,0));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0,
                         0,0,0,0,1,1,32'h8000_0100,0));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0,0,0,0,32'h0,1));
        tbl.push_back(mk(0,0,0,0, 1,32'hBFC0_0380, 1,32'h8000_0200,
                         0,0,0,0,0,0,32'h0,1));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0,
                         0,0,0,0,1,1,32'hBFC0_0380,1));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0,0,0,0,32'h0,2));
        tbl.push_back(mk(0,1,0,0, 0,0, 1,32'h1000,
                         1,1,0,0,0,0,32'h0,2));
        tbl.push_back(mk(0,1,1,1, 0,0, 0,0, 1,1,0,0,1,0,32'h1000,2));
        tbl.push_back(mk(0,1,0,0, 0,0, 0,0, 1,1,0,0,1,0,32'h1000,2));
        tbl.push_back(mk(0,1,0,0, 0,0, 0,0, 1,1,0,0,1,0,32'h1000,2));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0,0,1,1,32'h1000,2));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0,0,0,0,32'h0,3));
        tbl.push_back(mk(0,0,0,0, 1,32'h2000, 0,0,
                         0,0,0,0,0,0,32'h0,3));
        tbl.push_back(mk(0,1,0,0, 0,0, 0,0, 1,1,0,0,1,0,32'h2000,3));
        tbl.push_back(mk(0,1,0,0, 0,0, 1,32'h3000,
                         1,1,0,0,1,0,32'h2000,3));
        tbl.push_back(mk(0,1,0,0, 0,0, 0,0, 1,1,0,0,1,0,32'h2000,3));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0,0,1,1,32'h2000,3));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0,0,0,0,32'h0,0));
        tbl.push_back(mk(0,0,0,0, 0,0, 1,32'h4000,
                         0,0,0,0,0,0,32'h0,0));
        tbl.push_back(mk(0,0,0,0, 1,32'h5000, 0,0,
                         0,0,0,0,1,0,32'h4000,0));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0,0,1,1,32'h5000,0));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0,0,0,0,32'h0,1));
        tbl.push_back(mk(0,0,0,0, 0,0, 1,32'h6000,
                         0,0,0,0,0,0,32'h0,1));
        tbl.push_back(mk(0,0,0,0, 0,0, 1,32'h7000,
                         0,0,0,0,1,0,32'h6000,1));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0,0,1,1,32'h7000,1));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0,0,0,0,32'h0,2));
        tbl.push_back(mk(0,1,0,0, 0,0, 1,32'h8000,
                         1,1,0,0,0,0,32'h0,2));
        tbl.push_back(mk(0,1,0,0, 0,0, 0,0, 1,1,0,0,1,0,32'h8000,2));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,0,0,1,0,32'h8000,2));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0,0,0,0,32'h0,0));

        idle_in();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #4;
            chk("stall_pc", i, 32'(stall_pc), 32'(tbl[i].e_spc));
            chk("stall_if", i, 32'(stall_if), 32'(tbl[i].e_sif));
            chk("stall_id", i, 32'(stall_id), 32'(tbl[i].e_sid));
            chk("stall_rn", i, 32'(stall_rn), 32'(tbl[i].e_srn));
            chk("flush_front", i, 32'(flush_front), 32'(tbl[i].e_fl));
            chk("redirect_valid", i, 32'(redirect_valid),
                32'(tbl[i].e_rv));
            chk("redirect_pc", i, redirect_pc, tbl[i].e_pc);
            chk("redirect_cnt", i, 32'(redirect_cnt), 32'(tbl[i].e_cnt));
            @(posedge clk);
            #1;
        end

        // Drained mispredict: exactly one pulse within a bounded window
        idle_in();
        br_miss_valid = 1'b1;
        br_target     = 32'h0000_A000;
        stall_req_if  = 1'b1;
        pulses        = 0;
        seen_pc       = '0;
        for (int c = 0; c < 10; c++) begin
            if (c == 1) br_miss_valid = 1'b0;
            if (c == 3) stall_req_if = 1'b0;
            #4;
            if (redirect_valid === 1'b1) begin
                pulses++;
                seen_pc = redirect_pc;
            end
            @(posedge clk);
            #1;
        end
        #4;
        chk("seq_pulses", 100, 32'(pulses), 32'd1);
        chk("seq_pc", 101, seen_pc, 32'h0000_A000);
        chk("seq_cnt", 102, 32'(redirect_cnt), 32'd1);
        chk("seq_idle", 103, 32'(flush_front), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
